// File: rtl/bp_bits_req_stream.sv
// Streaming bits-required engine: groups signed residuals into blocks and
// reports the minimum SM/TC field width. Optional stats: BP_BITS_REQ_STATS_EN.
module bp_bits_req_stream #(
  parameter int SAMPLE_W  = 10,
  parameter int BLOCK_LEN = 4,
  parameter int BITS_W    = 4,
  parameter int CNT_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SAMPLE_W-1:0]           in_sample,
  input  logic [1:0]                    ecgidx,
  input  logic                          flush,
  output logic                          flush_ack,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BITS_W-1:0]             out_bits_req,
  output logic                          out_tc,
  output logic [CNT_W-1:0]              out_count,
`ifdef BP_BITS_REQ_STATS_EN
  output logic [15:0]                   blk_cnt,
  output logic [BITS_W-1:0]             peak_bits,
`endif
  output logic [BLOCK_LEN*SAMPLE_W-1:0] out_block
);

  localparam int BW = BLOCK_LEN * SAMPLE_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

  function automatic logic [BITS_W-1:0] msb_w(input logic [SAMPLE_W:0] v);
    msb_w = '0;
    for (int i = 0; i <= SAMPLE_W; i++)
      if (v[i]) msb_w = BITS_W'(i + 1);
  endfunction

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BITS_W-1:0] run_max_q, run_max_d;
  logic              tc_q, tc_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic              ov_q, ov_d;
  logic [BITS_W-1:0] obits_q, obits_d;
  logic              otc_q, otc_d;
  logic [CNT_W-1:0]  ocnt_q, ocnt_d;
  logic [BW-1:0]     oblk_q, oblk_d;

  logic [SAMPLE_W:0] ext, mag, inv;
  logic [BITS_W-1:0] sm_w, tc_w, w, new_max;
  logic              emit_ok, accept, cur_tc, complete;
  logic [BW-1:0]     blk_new;

  always_comb begin
    // magnitude at SAMPLE_W+1 bits so the most-negative value fits
    ext      = {in_sample[SAMPLE_W-1], in_sample};
    mag      = ext[SAMPLE_W] ? (~ext + 1'b1) : ext;
    inv      = ext[SAMPLE_W] ? ~ext : ext;
    sm_w     = msb_w(mag);
    tc_w     = (in_sample == '0) ? '0 : msb_w(inv) + 1'b1;
    emit_ok  = !ov_q || out_ready;
    in_ready = (cnt_q != LAST) || emit_ok;
    accept   = in_valid && in_ready;
    cur_tc   = (cnt_q == '0) ? (ecgidx == 2'd3) : tc_q;
    w        = cur_tc ? tc_w : sm_w;
    new_max  = (cnt_q == '0 || w > run_max_q) ? w : run_max_q;
    blk_new  = acc_q;
    for (int i = 0; i < BLOCK_LEN; i++)
      if (accept && CNT_W'(i) == cnt_q)
        blk_new[i*SAMPLE_W +: SAMPLE_W] = in_sample;
    flush_ack = flush && emit_ok && (cnt_q != '0 || accept);
    complete  = (accept && cnt_q == LAST) || flush_ack;

    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    tc_d      = tc_q;
    acc_d     = acc_q;
    ov_d      = ov_q && !out_ready;
    obits_d   = obits_q;
    otc_d     = otc_q;
    ocnt_d    = ocnt_q;
    oblk_d    = oblk_q;

    if (complete) begin
      ov_d      = 1'b1;
      obits_d   = accept ? new_max : run_max_q;
      otc_d     = accept ? cur_tc : tc_q;
      ocnt_d    = cnt_q + CNT_W'(accept);
      oblk_d    = blk_new;
      cnt_d     = '0;
      run_max_d = '0;
      acc_d     = '0;
    end else if (accept) begin
      cnt_d     = cnt_q + 1'b1;
      run_max_d = new_max;
      tc_d      = cur_tc;
      acc_d     = blk_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      run_max_q <= '0;
      tc_q      <= 1'b0;
      acc_q     <= '0;
      ov_q      <= 1'b0;
      obits_q   <= '0;
      otc_q     <= 1'b0;
      ocnt_q    <= '0;
      oblk_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      tc_q      <= tc_d;
      acc_q     <= acc_d;
      ov_q      <= ov_d;
      obits_q   <= obits_d;
      otc_q     <= otc_d;
      ocnt_q    <= ocnt_d;
      oblk_q    <= oblk_d;
    end
  end

  assign out_valid    = ov_q;
  assign out_bits_req = obits_q;
  assign out_tc       = otc_q;
  assign out_count    = ocnt_q;
  assign out_block    = oblk_q;

`ifdef BP_BITS_REQ_STATS_EN
  logic [15:0]       blk_cnt_q, blk_cnt_d;
  logic [BITS_W-1:0] peak_q, peak_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    peak_d    = peak_q;
    if (complete) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
      if (obits_d > peak_q) peak_d = obits_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_q <= '0;
      peak_q    <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      peak_q    <= peak_d;
    end
  end

  assign blk_cnt   = blk_cnt_q;
  assign peak_bits = peak_q;
`endif

endmodule

// File: tb/tb_bp_bits_req_stream.sv
// Scoreboard bench for bp_bits_req_stream: a reference model pushes the
// expected block on each completion; a negedge monitor pops and compares.
module tb_bp_bits_req_stream;
  localparam int SW = 10;
  localparam int BL = 4;
  localparam int BTW = 4;
  localparam int CW = 4;

  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0, in_ready;
  logic [SW-1:0] in_sample = '0;
  logic [1:0] ecgidx = '0;
  logic flush = 0, flush_ack;
  logic out_valid, out_ready = 1;
  logic [BTW-1:0] out_bits_req;
  logic out_tc;
  logic [CW-1:0] out_count;
  logic [BL*SW-1:0] out_block;
`ifdef BP_BITS_REQ_STATS_EN
  logic [15:0] blk_cnt;
  logic [BTW-1:0] peak_bits;
`endif

  bp_bits_req_stream #(.SAMPLE_W(SW), .BLOCK_LEN(BL), .BITS_W(BTW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .ecgidx(ecgidx), .flush(flush),
    .flush_ack(flush_ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_bits_req(out_bits_req), .out_tc(out_tc), .out_count(out_count),
`ifdef BP_BITS_REQ_STATS_EN
    .blk_cnt(blk_cnt), .peak_bits(peak_bits),
`endif
    .out_block(out_block)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bits;
    logic tc;
    int count;
    logic [BL*SW-1:0] blk;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  bit rnd_rdy = 0;

  int m_cnt = 0, m_max = 0;
  logic m_tc = 0;
  logic [BL*SW-1:0] m_blk = '0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int sm_w(int x);
    int a = (x < 0) ? -x : x;
    int n = 0;
    while ((1 << n) - 1 < a) n++;
    return n;
  endfunction

  function automatic int tc_w(int x);
    int n = 1;
    if (x == 0) return 0;
    while (!(x >= -(1 << (n - 1)) && x <= (1 << (n - 1)) - 1)) n++;
    return n;
  endfunction

  task automatic model_push();
    exp_t e;
    e.bits = m_max; e.tc = m_tc; e.count = m_cnt; e.blk = m_blk;
    q.push_back(e);
    m_cnt = 0; m_max = 0; m_blk = '0;
  endtask

  task automatic send(int x, logic [1:0] idx);
    logic signed [SW-1:0] s;
    int w;
    bit done = 0;
    s = SW'(x);
    in_valid = 1; in_sample = s; ecgidx = idx;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
    end
    if (!done) check("send_timeout", 1, 0);
    else begin
      if (m_cnt == 0) m_tc = (idx == 2'd3);
      w = m_tc ? tc_w(x) : sm_w(x);
      if (w > m_max || m_cnt == 0) m_max = w;
      m_blk[m_cnt*SW +: SW] = s;
      m_cnt++;
      if (m_cnt == BL) model_push();
    end
    #1 in_valid = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    @(negedge clk);
    check("flush_ack", flush_ack, m_cnt > 0);
    @(posedge clk);
    if (m_cnt > 0) model_push();
    #1 flush = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() > 0; k++) @(posedge clk);
    check("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  // monitor: compare on handshake, check stability while stalled
  initial forever begin
    @(negedge clk);
    if (out_valid) begin
      if (q.size() == 0) check("spurious_out", 1, 0);
      else begin
        check("bits", out_bits_req, q[0].bits);
        check("tc", out_tc, q[0].tc);
        check("count", out_count, q[0].count);
        check("block", out_block, q[0].blk);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    rst = 1; #12; rst = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flush_ack", flush_ack, 0);
    @(posedge clk); #1;

    // SM basic
    send(3, 0); send(-7, 0); send(0, 0); send(1, 0);
    drain();
    // TC edges, SM most-negative
    send(-512, 3); send(0, 3); send(0, 3); send(0, 3);
    send(1, 3); send(0, 3); send(0, 3); send(0, 3);
    send(0, 3); send(0, 3); send(0, 3); send(0, 3);
    send(-512, 0); send(0, 0); send(0, 0); send(0, 0);
    send(4, 3); send(-4, 3); send(-2, 3); send(-1, 3);
    drain();
    // ties and mode latch
    send(5, 0); send(-5, 0); send(5, 3); send(5, 3);
    drain();

    // backpressure over two blocks
    out_ready = 0;
    send(7, 0); send(1, 0); send(2, 0); send(3, 0);
    send(-9, 0); send(4, 0); send(6, 0);
    in_valid = 1; in_sample = SW'(100); ecgidx = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1;
    send(100, 0);
    drain();

    // flush
    send(2, 0); send(-1, 0);
    do_flush();
    drain();
    do_flush();

    // random traffic with random backpressure
    rnd_rdy = 1;
    for (int b = 0; b < 24; b++)
      send(int'($signed(SW'($urandom_range(0, 1023)))), 2'($urandom_range(0, 3)));
    rnd_rdy = 0; #1 out_ready = 1;
    drain();

    // reset mid-block
    send(300, 0); send(-300, 0);
    rst = 1; #3; rst = 0;
    m_cnt = 0; m_max = 0; m_blk = '0;
    @(posedge clk); #1;
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    drain();
`ifdef BP_BITS_REQ_STATS_EN
    check("blk_cnt", blk_cnt, 1);
    check("peak_bits", peak_bits, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end
endmodule

// File: doc/bp_bits_req_stream.md
# bp_bits_req_stream

Streaming, parametrised bits-required engine for the BP-mode ECG encoder. It accepts signed residual samples one per cycle over a valid/ready handshake and groups them into blocks of BLOCK_LEN. For each block it emits the minimum field width, sign-magnitude or two's-complement, that holds every sample, together with the buffered block data. It sits between the residual predictor and the bit packer.

## Interface
- SAMPLE_W, 10, sample width in bits.
- BLOCK_LEN, 4, samples per block, range 2..16.
- BITS_W, 4, width of the bits-required result; must satisfy 2^BITS_W > SAMPLE_W.
- CNT_W, 4, width of the count field; must satisfy 2^CNT_W > BLOCK_LEN.

Ports:
- clk, input, 1, the single clock.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, sample present.
- in_ready, output, 1, sample accepted when in_valid && in_ready.
- in_sample, input, SAMPLE_W, signed residual.
- ecgidx, input, 2, coding mode; sampled with the first sample of each block.
- flush, input, 1, request to emit the current partial block.
- flush_ack, output, 1, flush honoured this cycle.
- out_valid, output, 1, result held.
- out_ready, input, 1, downstream accepts.
- out_bits_req, output, BITS_W, required width for the block.
- out_tc, output, 1, 1 = two's-complement rule used, 0 = sign-magnitude.
- out_count, output, CNT_W, number of real samples in the block (1..BLOCK_LEN).
- out_block, output, BLOCK_LEN*SAMPLE_W, samples with sample 0 at the LSBs; unused slots are 0.

## Operation
**Per-sample width**
- The sample value 0 gives width 0 in both modes.
- Sign-magnitude (SM): the smallest n with |x| <= 2^n - 1. Examples: ±1 -> 1, ±3 -> 2, ±4 -> 3, -512 -> 10.
- Two's-complement (TC): the smallest n >= 1 with -2^(n-1) <= x <= 2^(n-1) - 1. Examples: -1 -> 1, 1 -> 2, -2 -> 2, -4 -> 3, 4 -> 4, -512 -> 10.
- The magnitude is computed at SAMPLE_W+1 bits so that the most-negative value does not overflow.

**Mode**
- ecgidx == 3 selects TC; 0..2 selects SM.
- The mode is latched when the sample at slot 0 is accepted.
- Changes to ecgidx mid-block are ignored.

**Accumulation**
- Slot counter cnt runs 0..BLOCK_LEN-1.
- Each accepted sample is written to slot cnt, and the running maximum is updated as run_max = max(run_max, width).
- This is a true maximum, so ties resolve correctly.
- On the first sample of a block, run_max restarts from that sample's width.

**Emission**
- emit_ok = !out_valid || out_ready.
- A block completes when either of these holds:
  - a sample is accepted at cnt == BLOCK_LEN-1, or
  - flush && emit_ok && (cnt > 0 || accept).
- On completion, the output register loads bits, mode, count and data (including any sample accepted in the same cycle). It then sets out_valid, clears the accumulator and sets cnt to 0.
- in_ready = (cnt != BLOCK_LEN-1) || emit_ok. Accumulation of the next block therefore overlaps a stalled output, and the block stalls only on its final slot.
- flush_ack = flush && emit_ok && (cnt > 0 || accept).
- A flush with nothing to emit, or with !emit_ok, is dropped; flush_ack stays 0 and the requester retries.
- out_valid falls on out_valid && out_ready unless a new block completes in the same cycle.

## Timing
- Reset clears cnt, run_max, the latched mode, the accumulator and all outputs. in_ready resets to 1. A reset mid-block discards the partial block.
- Latency: out_valid rises the cycle after the completing accept or flush.
- Output fields stay stable while out_valid && !out_ready.
- Throughput is one sample per cycle, with no bubble between blocks while out_ready = 1.
- Simultaneous output accept and new completion: the new block replaces the old one and out_valid stays 1.

## Configuration
- BP_BITS_REQ_STATS_EN defined:
  - adds output blk_cnt [15:0], which counts emitted blocks and wraps from 65535 to 0;
  - adds output peak_bits [BITS_W-1:0], a sticky maximum of out_bits_req;
  - both are cleared by rst.
- BP_BITS_REQ_STATS_EN undefined: these ports and their logic are absent.

## Test plan
- **SM basic.** BLOCK_LEN=4, ecgidx=0, samples 3, -7, 0, 1, out_ready=1 -> out_bits_req=3, out_tc=0, out_count=4, out_valid high for 1 cycle.
- **TC edges.** ecgidx=3: samples -512, 0, 0, 0 -> 10; samples 1, 0, 0, 0 -> 2; samples 0, 0, 0, 0 -> 0. The same -512 block with ecgidx=0 -> 10.
- **Ties and mode latch.** ecgidx=0 for samples 5, -5; ecgidx=3 for samples 5, 5 -> out_bits_req=3, out_tc=0.
- **Backpressure.** out_ready=0 for 10 cycles over two blocks:
  - block 1 is held stable;
  - block 2 fills slots 0..2;
  - in_ready=0 at slot 3;
  - on out_ready=1, block 2 completes and follows with no sample loss.
- **Flush.** Samples 2, -1, then flush -> flush_ack=1, out_count=2, out_bits_req=2, slots 2..3 zero. Flush with cnt=0 -> flush_ack=0.
- **Reset mid-block.** Assert rst after 2 samples, then send 4 samples of 1 -> a single block with out_bits_req=1 and out_count=4. With BP_BITS_REQ_STATS_EN, blk_cnt=1.
